// File: rtl/osr_pkg.sv
// osr_pkg: shared PIO constants and the shift-direction encoding used by osr and isr.
package osr_pkg;
    localparam int         DATA_W      = 32;
    localparam logic [5:0] EMPTY_COUNT = 6'd32;
    typedef enum logic {SHIFT_LEFT = 1'b0, SHIFT_RIGHT = 1'b1} shift_dir_e;
endpackage

// File: rtl/osr.sv
// osr: PIO output shift register with OUT/PULL/MOV handling.
// Autopull and background refill are built only when OSR_AUTOPULL_EN is defined.
module osr
    import osr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              penable,
    input  logic              dir,
    input  logic [4:0]        shift,
    input  logic              do_shift,
    input  logic              do_pull,
    input  logic              pull_block,
    input  logic              set,
    input  logic [DATA_W-1:0] din,
    input  logic              auto_pull,
    input  logic [4:0]        pull_thresh,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_valid,
    output logic              fifo_pop,
    output logic [DATA_W-1:0] dout,
    output logic              out_valid,
    output logic              stall,
    output logic [DATA_W-1:0] osr_value,
    output logic [5:0]        shift_count
);
    logic [DATA_W-1:0] r_shift_reg, w_shift_next;
    logic [5:0]        r_count, w_count_next, w_n;
    logic [6:0]        w_sum;
    logic              w_en, w_refill, w_pull_noop;

    assign w_n   = (shift == 5'd0) ? EMPTY_COUNT : {1'b0, shift};
    assign w_en  = penable && !reset;
    assign w_sum = {1'b0, r_count} + {1'b0, w_n};

`ifdef OSR_AUTOPULL_EN
    logic [5:0] w_thresh;
    assign w_thresh    = (pull_thresh == 5'd0) ? EMPTY_COUNT : {1'b0, pull_thresh};
    assign w_refill    = auto_pull && (r_count >= w_thresh);
    assign w_pull_noop = auto_pull && (r_count < w_thresh);
`else
    logic w_unused;
    assign w_unused    = ^{auto_pull, pull_thresh};
    assign w_refill    = 1'b0;
    assign w_pull_noop = 1'b0;
`endif

    // Reset gates every strobe so no pop or output escapes in the reset cycle.
    always_comb begin
        w_shift_next = r_shift_reg;
        w_count_next = r_count;
        stall        = 1'b0;
        fifo_pop     = 1'b0;
        out_valid    = 1'b0;
        dout         = '0;
        if (w_en) begin
            if (set) begin
                w_shift_next = din;
                w_count_next = '0;
            end else if (do_pull) begin
                if (!w_pull_noop) begin
                    if (fifo_valid) begin
                        fifo_pop     = 1'b1;
                        w_shift_next = fifo_data;
                        w_count_next = '0;
                    end else if (pull_block) begin
                        stall = 1'b1;
                    end else begin
                        w_shift_next = din;
                        w_count_next = '0;
                    end
                end
            end else if (do_shift) begin
                if (w_refill) begin
                    stall = 1'b1;
                    if (fifo_valid) begin
                        fifo_pop     = 1'b1;
                        w_shift_next = fifo_data;
                        w_count_next = '0;
                    end
                end else begin
                    out_valid    = 1'b1;
                    dout         = (shift_dir_e'(dir) == SHIFT_RIGHT)
                                 ? (r_shift_reg & ~({DATA_W{1'b1}} << w_n))
                                 : (r_shift_reg >> (EMPTY_COUNT - w_n));
                    w_shift_next = (shift_dir_e'(dir) == SHIFT_RIGHT)
                                 ? (r_shift_reg >> w_n) : (r_shift_reg << w_n);
                    w_count_next = (w_sum > 7'd32) ? EMPTY_COUNT : w_sum[5:0];
                end
            end else if (w_refill && fifo_valid) begin
                fifo_pop     = 1'b1;
                w_shift_next = fifo_data;
                w_count_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift_reg <= '0;
            r_count     <= EMPTY_COUNT;
        end else begin
            r_shift_reg <= w_shift_next;
            r_count     <= w_count_next;
        end
    end

    assign osr_value   = r_shift_reg;
    assign shift_count = r_count;
endmodule
